// File: rtl/rs_key_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_key_seq                                                   |
// | Description : Iterative Twofish RS key-schedule multiply. One key byte per |
// |               clock feeds four GF(2^8) row multipliers; S0 half, then S1.  |
// |               Optional RS_KEY_SEQ_ABORT_EN adds an Abort input.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rs_key_seq #(
    parameter logic [8:0] POLY = 9'b101001101
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [127:0] Key,
`ifdef RS_KEY_SEQ_ABORT_EN
    input  logic         Abort,
`endif
    output logic         Busy,
    output logic         Done,
    output logic [31:0]  S0,
    output logic [31:0]  S1
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CALC0 = 2'd1;
    localparam logic [1:0] c_ST_CALC1 = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        CALC0 = c_ST_CALC0,
        CALC1 = c_ST_CALC1,
        DONE  = c_ST_DONE
    } state_t;

    // RS rows packed row0..row3, byte j of each row at [8*(7-j) +: 8]
    localparam logic [255:0] c_COEF = {
        64'h01A4_5587_5A58_DB9E,
        64'hA456_82F3_1EC6_68E5,
        64'h02A1_FCC1_47AE_3D19,
        64'hA455_875A_58DB_9E03
    };

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_cnt;
    logic [31:0]    r_acc;
    logic [127:0]   r_key;
    logic [31:0]    r_s0;
    logic [31:0]    r_s1;

    logic           w_abort;
    logic           w_last;
    logic [2:0]     w_sel;
    logic [63:0]    w_half;
    logic [7:0]     w_byte;
    logic [31:0]    w_prod;
    logic [31:0]    w_acc_nxt;

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ POLY[7:0]) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

`ifdef RS_KEY_SEQ_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last    = (r_cnt == 3'd7);
    assign w_sel     = ~r_cnt;
    assign w_half    = (r_state == CALC1) ? r_key[63:0] : r_key[127:64];
    assign w_byte    = w_half[{w_sel, 3'b000} +: 8];
    assign w_acc_nxt = r_acc ^ w_prod;

    for (genvar g = 0; g < 4; g++) begin : g_row
        localparam logic [63:0] c_ROW = c_COEF[255 - 64*g -: 64];
        assign w_prod[31 - 8*g -: 8] = f_gmul(c_ROW[{w_sel, 3'b000} +: 8], w_byte);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = CALC0;
                end
            end
            CALC0: begin
                Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = CALC1;
                end
            end
            CALC1: begin
                Busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                Done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The final product of a half goes straight into S0/S1; the accumulator restarts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
            r_acc <= 32'h0;
            r_key <= 128'h0;
            r_s0  <= 32'h0;
            r_s1  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_key <= Key;
                        r_cnt <= 3'd0;
                        r_acc <= 32'h0;
                    end
                end
                CALC0, CALC1: begin
                    if (w_abort) begin
                        r_cnt <= 3'd0;
                        r_acc <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last) begin
                            r_acc <= 32'h0;
                            if (r_state == CALC0) begin
                                r_s0 <= w_acc_nxt;
                            end else begin
                                r_s1 <= w_acc_nxt;
                            end
                        end else begin
                            r_acc <= w_acc_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign S0 = r_s0;
    assign S1 = r_s1;

endmodule
`default_nettype wire

// File: tb/tb_rs_key_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rs_key_seq                                                |
// | Description : Self-checking bench for rs_key_seq (vectors + random model). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rs_key_seq;

    logic         clk;
    logic         rst;
    logic         Start;
    logic [127:0] Key;
    logic         Abort;
    logic         Busy;
    logic         Done;
    logic [31:0]  S0;
    logic [31:0]  S1;

    int           total;
    int           bad;
    logic [31:0]  prev_s0;
    logic [31:0]  prev_s1;
    logic [7:0]   coef [4][8];

    typedef struct {
        logic [127:0] key;
        logic [31:0]  s0;
        logic [31:0]  s1;
    } vec_t;

    vec_t vt [6];

    rs_key_seq dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Key   (Key),
`ifdef RS_KEY_SEQ_ABORT_EN
        .Abort (Abort),
`endif
        .Busy  (Busy),
        .Done  (Done),
        .S0    (S0),
        .S1    (S1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Full carry-less product, then long division by the field polynomial
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] pl;
        p  = 15'h0;
        pl = 15'h14D;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (pl << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] rs_half(input logic [63:0] h);
        logic [7:0]  row [4];
        logic [7:0]  kb;
        for (int r = 0; r < 4; r++) row[r] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            kb = h[63 - 8*j -: 8];
            for (int r = 0; r < 4; r++) row[r] = row[r] ^ gf_mul(coef[r][j], kb);
        end
        return {row[0], row[1], row[2], row[3]};
    endfunction

`ifdef RS_KEY_SEQ_ABORT_EN
    // Solve for a 64-bit half (upper four bytes only) whose RS image is all ones
    function automatic logic [63:0] solve_ones();
        logic [32:0] m [32];
        logic [31:0] col [32];
        logic [32:0] tmp;
        logic [31:0] x;
        int          p;
        for (int c = 0; c < 32; c++) col[c] = rs_half({32'h1 << c, 32'h0});
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) m[r][c] = col[c][r];
            m[r][32] = 1'b1;
        end
        for (int c = 0; c < 32; c++) begin
            p = -1;
            for (int r = c; r < 32; r++) if (p < 0 && m[r][c]) p = r;
            if (p >= 0) begin
                tmp  = m[p];
                m[p] = m[c];
                m[c] = tmp;
                for (int r = 0; r < 32; r++) if (r != c && m[r][c]) m[r] = m[r] ^ m[c];
            end
        end
        for (int c = 0; c < 32; c++) x[c] = m[c][32];
        return {x, 32'h0};
    endfunction
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_calc(input logic [127:0] k, input logic [31:0] e0, input logic [31:0] e1,
                           input bit junk, input string tag);
        int lat;
        @(negedge clk);
        Start = 1'b1;
        Key   = k;
        @(negedge clk);
        Start = 1'b0;
        lat   = 0;
        chk({tag, " busy_after_start"}, 64'(Busy), 64'd1);
        while (!Done && lat < 40) begin
            if (junk) begin
                Start = 1'($urandom % 2);
                Key   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            lat++;
            if (lat == 7) chk({tag, " s0_hold"}, 64'(S0), 64'(prev_s0));
            if (lat == 8) begin
                chk({tag, " s0_at_e8"}, 64'(S0), 64'(e0));
                chk({tag, " s1_hold"}, 64'(S1), 64'(prev_s1));
            end
        end
        Start = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'd16);
        chk({tag, " busy_at_done"}, 64'(Busy), 64'd0);
        chk({tag, " s0"}, 64'(S0), 64'(e0));
        chk({tag, " s1"}, 64'(S1), 64'(e1));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(Done), 64'd0);
        prev_s0 = e0;
        prev_s1 = e1;
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] k2;
        int           dones;
        int           first;
        int           second;

        total = 0;
        bad   = 0;
        coef[0] = '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E};
        coef[1] = '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5};
        coef[2] = '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19};
        coef[3] = '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03};

        vt[0] = '{128'h0,                           32'h00000000, 32'h00000000};
        vt[1] = '{{8'h01, 120'h0},                  32'h01A402A4, 32'h00000000};
        vt[2] = '{{8'h02, 120'h0},                  32'h02050405, 32'h00000000};
        vt[3] = '{{56'h0, 8'h01, 64'h0},            32'h9EE51903, 32'h00000000};
        vt[4] = '{{120'h0, 8'h01},                  32'h00000000, 32'h9EE51903};
        vt[5] = '{{8'h01, 112'h0, 8'h01},           32'h01A402A4, 32'h9EE51903};

        // Reset, with Start asserted alongside to show rst wins
        rst   = 1'b1;
        Start = 1'b1;
        Key   = {4{32'hDEADBEEF}};
        Abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(Busy), 64'd0);
        chk("reset done", 64'(Done), 64'd0);
        chk("reset s0", 64'(S0), 64'd0);
        chk("reset s1", 64'(S1), 64'd0);
        Start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle after reset", 64'(Busy), 64'd0);
        prev_s0 = 32'h0;
        prev_s1 = 32'h0;

        for (int i = 0; i < 6; i++)
            do_calc(vt[i].key, vt[i].s0, vt[i].s1, 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            do_calc(k, rs_half(k[127:64]), rs_half(k[63:0]), 1'b1, $sformatf("rand%0d", i));
        end

        // Re-pulse Start with another key at E5
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k;
        @(negedge clk);
        Start = 1'b1;
        Key   = k;
        @(negedge clk);
        Start = 1'b0;
        dones = 0;
        first = -1;
        for (int lat = 0; lat < 30; lat++) begin
            if (lat == 4) begin
                Start = 1'b1;
                Key   = k2;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                dones++;
                if (first < 0) first = lat;
            end
            @(negedge clk);
        end
        chk("repulse done_count", 64'(dones), 64'd1);
        chk("repulse latency", 64'(first), 64'd16);
        chk("repulse s0", 64'(S0), 64'(rs_half(k[127:64])));
        chk("repulse s1", 64'(S1), 64'(rs_half(k[63:0])));
        prev_s0 = rs_half(k[127:64]);
        prev_s1 = rs_half(k[63:0]);

        // Start held high: second request accepted right after Done
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        Start  = 1'b1;
        Key    = k;
        first  = -1;
        second = -1;
        @(posedge clk);
        for (int lat = 0; lat < 45; lat++) begin
            @(negedge clk);
            if (Done) begin
                if (first < 0) begin
                    first = lat;
                    chk("b2b first s0", 64'(S0), 64'(rs_half(k[127:64])));
                    chk("b2b first s1", 64'(S1), 64'(rs_half(k[63:0])));
                    Key = k2;
                end else if (second < 0) begin
                    second = lat;
                    Start  = 1'b0;
                end else begin
                    second = 999;
                end
            end
        end
        Start = 1'b0;
        chk("b2b first latency", 64'(first), 64'd16);
        chk("b2b second latency", 64'(second), 64'd34);
        chk("b2b second s0", 64'(S0), 64'(rs_half(k2[127:64])));
        chk("b2b second s1", 64'(S1), 64'(rs_half(k2[63:0])));
        prev_s0 = rs_half(k2[127:64]);
        prev_s1 = rs_half(k2[63:0]);

        // Reset sampled at E10
        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        Start = 1'b1;
        Key   = k;
        @(negedge clk);
        Start = 1'b0;
        for (int lat = 0; lat < 9; lat++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", 64'(Busy), 64'd0);
        chk("midreset s0", 64'(S0), 64'd0);
        chk("midreset s1", 64'(S1), 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) dones++;
            @(negedge clk);
        end
        chk("midreset no_done", 64'(dones), 64'd0);
        prev_s0 = 32'h0;
        prev_s1 = 32'h0;
        k = {$urandom, $urandom, $urandom, $urandom};
        do_calc(k, rs_half(k[127:64]), rs_half(k[63:0]), 1'b0, "after_reset");

`ifdef RS_KEY_SEQ_ABORT_EN
        k = {solve_ones(), solve_ones()};
        do_calc(k, rs_half(k[127:64]), rs_half(k[63:0]), 1'b0, "ones");
        chk("ones s0_all_set", 64'(S0), 64'hFFFFFFFF);
        k = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        Start = 1'b1;
        Key   = k;
        @(negedge clk);
        Start = 1'b0;
        for (int lat = 0; lat < 3; lat++) @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        chk("abort busy", 64'(Busy), 64'd0);
        chk("abort done", 64'(Done), 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) dones++;
            @(negedge clk);
        end
        chk("abort no_done", 64'(dones), 64'd0);
        chk("abort s0", 64'(S0), 64'(prev_s0));
        chk("abort s1", 64'(S1), 64'(prev_s1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_key_seq.md
RS_KEY_SEQ -- requirements
Module: rs_key_seq

Interface
REQ-001 SHALL have parameter POLY, default 9'b101001101, the GF(2^8) reduction polynomial x^8+x^6+x^3+x^2+1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Start  input  1  request to begin one computation; sampled only in IDLE.
REQ-005 SHALL have port Key  input  128  128-bit Twofish key; captured on the accepted Start edge.
REQ-006 SHALL have port Busy  output  1  high while a computation is in progress.
REQ-007 SHALL have port Done  output  1  one-cycle pulse; S0/S1 are valid from this cycle on.
REQ-008 SHALL have port S0  output  32  RS result for key bytes Key[127:64].
REQ-009 SHALL have port S1  output  32  RS result for key bytes Key[63:0].

Function
REQ-010 SHALL compute S0 and S1 iteratively with four GF(2^8) multipliers modulo POLY (one per RS row) and four 8-bit XOR accumulators; it SHALL NOT use 64 parallel multipliers.
REQ-011 SHALL use these RS row coefficients, indexed by byte j=0..7:
  - row0 = 01 A4 55 87 5A 58 DB 9E
  - row1 = A4 56 82 F3 1E C6 68 E5
  - row2 = 02 A1 FC C1 47 AE 3D 19
  - row3 = A4 55 87 5A 58 DB 9E 03
REQ-012 SHALL take byte j of the S0 half from Key[127-8j : 120-8j] and byte j of the S1 half from Key[63-8j : 56-8j].
REQ-013 SHALL form each result as {row0, row1, row2, row3}, with row0 in bits [31:24], where rowN = XOR over j of coefN[j]*byte[j].
REQ-014 SHALL implement FSM states IDLE, CALC0, CALC1, DONE.
  - IDLE -> CALC0 when Start=1.
  - CALC0 -> CALC1 after 8 cycles.
  - CALC1 -> DONE after 8 cycles.
  - DONE -> IDLE unconditionally.
REQ-015 SHALL use a 3-bit byte counter, cleared on entry to CALC0 and CALC1, that wraps 7 -> 0 at each half boundary; the accumulators SHALL clear at the same time.
REQ-016 SHALL, on edge E0 where Start=1 in IDLE, capture Key and set Busy=1.
  - Accumulation occurs on edges E1..E16.
  - S0 is written at E8 and S1 at E16.
  - Done=1 and Busy=0 during the cycle after E16: latency 16 clocks from the Start edge.
REQ-017 SHALL ignore Start and Key changes while Busy=1 or Done=1; the computation SHALL use the captured Key.
REQ-018 SHALL accept a Start held high continuously as back-to-back requests: a new computation is accepted in the first IDLE cycle after Done.
REQ-019 SHALL hold S0/S1 stable between completions.
  - S0 changes only at E8 of a computation.
  - S1 changes only at E16 of a computation.

Reset
REQ-020 SHALL, when rst=1 at an edge, force state=IDLE, counter=0, accumulators=0, captured key=0, Busy=0, Done=0, S0=0, S1=0.
REQ-021 SHALL let rst override all other inputs, including Start on the same edge and reset mid-computation; a rst mid-computation SHALL produce no Done pulse.

Configuration
REQ-022 SHALL, when RS_KEY_SEQ_ABORT_EN is defined, add port Abort (input, 1).
  - Abort=1 in CALC0 or CALC1 returns the FSM to IDLE on that edge.
  - Busy falls and no Done pulse is issued.
  - S0/S1 are left unchanged, except that an S0 already written at E8 remains.
  - Abort takes priority over counter wrap; Abort in IDLE or DONE has no effect.
REQ-023 SHALL, when RS_KEY_SEQ_ABORT_EN is undefined, have no Abort port; every accepted Start SHALL complete unless rst is asserted.

Verification
REQ-024 SHALL cover: Key=128'h0, Start pulse -> Done exactly 16 clocks after the Start edge, S0=32'h00000000, S1=32'h00000000.
REQ-025 SHALL cover: Key[127:120]=8'h01, other bits 0 -> S0=32'h01A402A4, S1=0; Key[127:120]=8'h02 -> S0=32'h02050405.
REQ-026 SHALL cover: Key[71:64]=8'h01 only -> S0=32'h9EE51903, S1=0; Key[7:0]=8'h01 only -> S0=0, S1=32'h9EE51903.
REQ-027 SHALL cover: Start re-pulsed with a different Key at E5 -> ignored; results match the first Key; exactly one Done pulse.
REQ-028 SHALL cover: rst asserted at E10 -> Busy=0, S0=S1=0 on the next cycle, no Done pulse; a new Start then completes correctly.
REQ-029 SHALL cover (RS_KEY_SEQ_ABORT_EN defined): Abort at E4 with prior S0=S1=32'hFFFFFFFF -> IDLE, Busy=0, no Done, S0 and S1 still 32'hFFFFFFFF.
